// File: rtl/dvfs_actuator.sv
// dvfs_actuator: turns optimizer error samples into saturating V/F level
// steps, runs a req/ack handshake with the regulator, then waits a settle
// interval. A regulator that never acks reverts the level and latches a
// sticky fault until reset.
// Ports: clk, rst_n (sync, active-low); err_valid/err_ready/err_mag/err_dir
// sample handshake; vf_req/vf_level/vf_ack regulator handshake;
// busy (REQ or SETTLE), sat (clamped-step pulse), fault (sticky timeout).
module dvfs_actuator #(
   parameter int          NUM_LEVELS     = 8,
   parameter int          LEVEL_W        = 3,
   parameter int          RESET_LEVEL    = 4,
   parameter logic [15:0] DEADBAND       = 16'd64,
   parameter logic [15:0] STEP2_THRESH   = 16'd1024,
   parameter int          SETTLE_CYCLES  = 16,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               err_valid,
   output logic               err_ready,
   input  logic [15:0]        err_mag,
   input  logic               err_dir,
   output logic               vf_req,
   output logic [LEVEL_W-1:0] vf_level,
   input  logic               vf_ack,
   output logic               busy,
   output logic               sat,
   output logic               fault
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_SETTLE,
      S_FAULT
   } state_t;

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int STL_W = $clog2(SETTLE_CYCLES + 1);
   // two extra bits give room for a sign and for cur+2 overflow
   localparam int SW = LEVEL_W + 2;
   localparam logic signed [SW-1:0] MAX_S = SW'(NUM_LEVELS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [STL_W-1:0] STL_LAST = STL_W'(SETTLE_CYCLES - 1);

   state_t             state, state_next;
   logic [LEVEL_W-1:0] prev_level, prev_level_next;
   logic [LEVEL_W-1:0] level_next;
   logic [TMR_W-1:0]   timer, timer_next;
   logic [STL_W-1:0]   settle_cnt, settle_cnt_next;
   logic               req_next, sat_next, fault_next;
   logic               ready_next, busy_next;

   logic signed [SW-1:0] cur_s, step_s, sum_s;
   logic [LEVEL_W-1:0]   target;

   // candidate level for the sample currently presented
   always_comb begin
      cur_s  = $signed({2'b00, vf_level});
      step_s = (err_mag > STEP2_THRESH) ? SW'(2) : SW'(1);
      sum_s  = err_dir ? (cur_s - step_s) : (cur_s + step_s);
      if (sum_s[SW-1])
         target = '0;
      else if (sum_s > MAX_S)
         target = MAX_S[LEVEL_W-1:0];
      else
         target = sum_s[LEVEL_W-1:0];
   end

   always_comb begin
      state_next      = state;
      prev_level_next = prev_level;
      level_next      = vf_level;
      timer_next      = timer;
      settle_cnt_next = settle_cnt;
      req_next        = vf_req;
      fault_next      = fault;
      sat_next        = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (err_valid && err_mag > DEADBAND) begin
               if (target == vf_level) begin
                  sat_next = 1'b1;
               end else begin
                  prev_level_next = vf_level;
                  level_next      = target;
                  req_next        = 1'b1;
                  timer_next      = '0;
                  state_next      = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (vf_ack) begin
               req_next        = 1'b0;
               settle_cnt_next = '0;
               state_next      = S_SETTLE;
            end else if (timer == TMR_LAST) begin
               level_next = prev_level;
               req_next   = 1'b0;
               fault_next = 1'b1;
               state_next = S_FAULT;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         S_SETTLE: begin
            if (settle_cnt == STL_LAST)
               state_next = S_IDLE;
            else
               settle_cnt_next = settle_cnt + 1'b1;
         end
         S_FAULT: begin
            req_next   = 1'b0;
            fault_next = 1'b1;
         end
         default: state_next = S_IDLE;
      endcase
      ready_next = (state_next == S_IDLE);
      busy_next  = (state_next == S_REQ) || (state_next == S_SETTLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         prev_level <= LEVEL_W'(RESET_LEVEL);
         vf_level   <= LEVEL_W'(RESET_LEVEL);
         timer      <= '0;
         settle_cnt <= '0;
         vf_req     <= 1'b0;
         sat        <= 1'b0;
         fault      <= 1'b0;
         err_ready  <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state      <= state_next;
         prev_level <= prev_level_next;
         vf_level   <= level_next;
         timer      <= timer_next;
         settle_cnt <= settle_cnt_next;
         vf_req     <= req_next;
         sat        <= sat_next;
         fault      <= fault_next;
         err_ready  <= ready_next;
         busy       <= busy_next;
      end
   end

endmodule

// File: tb/tb_dvfs_actuator.sv
// Directed testbench for dvfs_actuator: deadband, step sizes, clamping,
// ack/settle timing, regulator timeout and mid-request reset.
module tb_dvfs_actuator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        err_valid;
   logic        err_ready;
   logic [15:0] err_mag;
   logic        err_dir;
   logic        vf_req;
   logic [2:0]  vf_level;
   logic        vf_ack;
   logic        busy;
   logic        sat;
   logic        fault;

   int checks = 0;
   int errors = 0;

   dvfs_actuator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .err_valid (err_valid),
      .err_ready (err_ready),
      .err_mag   (err_mag),
      .err_dir   (err_dir),
      .vf_req    (vf_req),
      .vf_level  (vf_level),
      .vf_ack    (vf_ack),
      .busy      (busy),
      .sat       (sat),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic send(input logic [15:0] mag, input logic dir);
      err_valid = 1'b1;
      err_mag   = mag;
      err_dir   = dir;
      tick();
      err_valid = 1'b0;
   endtask

   // ack the pending request and sit out the settle interval
   task automatic finish_req();
      vf_ack = 1'b1;
      tick();
      vf_ack = 1'b0;
      repeat (16) tick();
   endtask

   task automatic test_reset();
      err_valid = 1'b0;
      err_mag   = '0;
      err_dir   = 1'b0;
      vf_ack    = 1'b0;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      checks++;
      if (err_ready !== 1'b1 || vf_req !== 1'b0 || busy !== 1'b0 ||
          sat !== 1'b0 || fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got rdy=%b req=%b busy=%b sat=%b flt=%b want 1 0 0 0 0",
                  err_ready, vf_req, busy, sat, fault);
      end
      checks++;
      if (vf_level !== 3'd4) begin
         errors++;
         $display("FAIL reset_level: got %0d want 4", vf_level);
      end
   endtask

   task automatic test_deadband();
      do_reset();
      send(16'd64, 1'b0);
      checks++;
      if (vf_req !== 1'b0 || vf_level !== 3'd4 || err_ready !== 1'b1 ||
          sat !== 1'b0) begin
         errors++;
         $display("FAIL deadband_64: got req=%b lvl=%0d rdy=%b sat=%b want 0 4 1 0",
                  vf_req, vf_level, err_ready, sat);
      end
      send(16'd65, 1'b0);
      checks++;
      if (vf_req !== 1'b1 || vf_level !== 3'd5 || err_ready !== 1'b0 ||
          busy !== 1'b1) begin
         errors++;
         $display("FAIL step_up_65: got req=%b lvl=%0d rdy=%b busy=%b want 1 5 0 1",
                  vf_req, vf_level, err_ready, busy);
      end
      finish_req();
      checks++;
      if (err_ready !== 1'b1 || vf_level !== 3'd5) begin
         errors++;
         $display("FAIL after_settle: got rdy=%b lvl=%0d want 1 5",
                  err_ready, vf_level);
      end
   endtask

   task automatic test_step_size();
      do_reset();
      send(16'd1025, 1'b1);
      checks++;
      if (vf_level !== 3'd2 || vf_req !== 1'b1) begin
         errors++;
         $display("FAIL step2_down: got lvl=%0d req=%b want 2 1", vf_level, vf_req);
      end
      finish_req();
      do_reset();
      send(16'd1024, 1'b1);
      checks++;
      if (vf_level !== 3'd3 || vf_req !== 1'b1) begin
         errors++;
         $display("FAIL step1_down_1024: got lvl=%0d req=%b want 3 1", vf_level, vf_req);
      end
      finish_req();
   endtask

   task automatic test_saturate();
      do_reset();
      send(16'd1025, 1'b0);
      finish_req();
      send(16'd65, 1'b0);
      finish_req();
      checks++;
      if (vf_level !== 3'd7) begin
         errors++;
         $display("FAIL reach_top: got %0d want 7", vf_level);
      end
      send(16'd2000, 1'b0);
      checks++;
      if (sat !== 1'b1 || vf_req !== 1'b0 || vf_level !== 3'd7 ||
          err_ready !== 1'b1) begin
         errors++;
         $display("FAIL sat_top: got sat=%b req=%b lvl=%0d rdy=%b want 1 0 7 1",
                  sat, vf_req, vf_level, err_ready);
      end
      tick();
      checks++;
      if (sat !== 1'b0) begin
         errors++;
         $display("FAIL sat_pulse_width: got %b want 0", sat);
      end
      do_reset();
      send(16'd1025, 1'b1);
      finish_req();
      send(16'd65, 1'b1);
      finish_req();
      send(16'd2000, 1'b1);
      checks++;
      if (vf_level !== 3'd0 || vf_req !== 1'b1 || sat !== 1'b0) begin
         errors++;
         $display("FAIL clamp_bottom: got lvl=%0d req=%b sat=%b want 0 1 0",
                  vf_level, vf_req, sat);
      end
      finish_req();
   endtask

   task automatic test_ack_settle();
      do_reset();
      send(16'd65, 1'b0);
      tick();
      tick();
      vf_ack = 1'b1;
      tick();
      vf_ack = 1'b0;
      checks++;
      if (vf_req !== 1'b0 || busy !== 1'b1 || err_ready !== 1'b0) begin
         errors++;
         $display("FAIL ack_drop: got req=%b busy=%b rdy=%b want 0 1 0",
                  vf_req, busy, err_ready);
      end
      err_valid = 1'b1;
      err_mag   = 16'd2000;
      err_dir   = 1'b0;
      vf_ack    = 1'b1;
      repeat (5) tick();
      err_valid = 1'b0;
      vf_ack    = 1'b0;
      repeat (10) tick();
      checks++;
      if (err_ready !== 1'b0 || busy !== 1'b1 || vf_level !== 3'd5 ||
          vf_req !== 1'b0) begin
         errors++;
         $display("FAIL settle_hold: got rdy=%b busy=%b lvl=%0d req=%b want 0 1 5 0",
                  err_ready, busy, vf_level, vf_req);
      end
      tick();
      checks++;
      if (err_ready !== 1'b1 || busy !== 1'b0 || vf_level !== 3'd5) begin
         errors++;
         $display("FAIL settle_exit: got rdy=%b busy=%b lvl=%0d want 1 0 5",
                  err_ready, busy, vf_level);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      send(16'd65, 1'b0);
      repeat (255) tick();
      checks++;
      if (fault !== 1'b0 || vf_req !== 1'b1 || vf_level !== 3'd5) begin
         errors++;
         $display("FAIL pre_timeout: got flt=%b req=%b lvl=%0d want 0 1 5",
                  fault, vf_req, vf_level);
      end
      tick();
      checks++;
      if (fault !== 1'b1 || vf_req !== 1'b0 || vf_level !== 3'd4 ||
          err_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout: got flt=%b req=%b lvl=%0d rdy=%b busy=%b want 1 0 4 0 0",
                  fault, vf_req, vf_level, err_ready, busy);
      end
      err_valid = 1'b1;
      err_mag   = 16'd2000;
      vf_ack    = 1'b1;
      repeat (20) tick();
      err_valid = 1'b0;
      vf_ack    = 1'b0;
      checks++;
      if (fault !== 1'b1 || err_ready !== 1'b0 || vf_level !== 3'd4 ||
          vf_req !== 1'b0) begin
         errors++;
         $display("FAIL fault_sticky: got flt=%b rdy=%b lvl=%0d req=%b want 1 0 4 0",
                  fault, err_ready, vf_level, vf_req);
      end
   endtask

   task automatic test_ack_at_timeout();
      do_reset();
      checks++;
      if (fault !== 1'b0 || err_ready !== 1'b1) begin
         errors++;
         $display("FAIL fault_reset: got flt=%b rdy=%b want 0 1", fault, err_ready);
      end
      send(16'd65, 1'b0);
      repeat (255) tick();
      vf_ack = 1'b1;
      tick();
      vf_ack = 1'b0;
      checks++;
      if (fault !== 1'b0 || vf_req !== 1'b0 || busy !== 1'b1 ||
          vf_level !== 3'd5) begin
         errors++;
         $display("FAIL ack_wins: got flt=%b req=%b busy=%b lvl=%0d want 0 0 1 5",
                  fault, vf_req, busy, vf_level);
      end
      repeat (16) tick();
      checks++;
      if (err_ready !== 1'b1 || fault !== 1'b0) begin
         errors++;
         $display("FAIL ack_wins_idle: got rdy=%b flt=%b want 1 0", err_ready, fault);
      end
   endtask

   task automatic test_reset_mid_req();
      do_reset();
      send(16'd65, 1'b0);
      tick();
      checks++;
      if (vf_level !== 3'd5 || vf_req !== 1'b1) begin
         errors++;
         $display("FAIL mid_req_setup: got lvl=%0d req=%b want 5 1", vf_level, vf_req);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (vf_level !== 3'd4 || vf_req !== 1'b0 || err_ready !== 1'b1 ||
          busy !== 1'b0 || fault !== 1'b0 || sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_req: got lvl=%0d req=%b rdy=%b busy=%b flt=%b sat=%b want 4 0 1 0 0 0",
                  vf_level, vf_req, err_ready, busy, fault, sat);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      err_valid = 1'b0;
      err_mag   = '0;
      err_dir   = 1'b0;
      vf_ack    = 1'b0;
      test_reset();
      test_deadband();
      test_step_size();
      test_saturate();
      test_ack_settle();
      test_timeout();
      test_ack_at_timeout();
      test_reset_mid_req();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
